if_id_skid_stage: RTL and testbench
===================================

// Module: if_id_skid_stage
// PURPOSE
//  Parametrised IF/ID pipeline stage with a valid/ready handshake. Replaces the plain
//  write/flush latch between instruction fetch and decode. Carries PC+4 and the
//  instruction, and pre-splits the instruction into opcode/rs/rt/rd/funct/imm fields.
//  An optional skid entry keeps in_ready registered, so the decode stall does not
//  ripple combinationally back into fetch.
// PARAMETERS
//  ADDR_W   32  width of the PC+4 payload
//  INSTR_W  32  instruction width; must be >= 32 (fields taken from bits [31:0])
//  SKID     1   1: two-entry skid buffer, registered in_ready; 0: single register
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous reset, active-low
//  in_valid      in   1        fetch presents a valid PC+4/instruction
//  in_ready      out  1        stage accepts input this cycle
//  in_pc_plus4   in   ADDR_W   PC+4 from fetch
//  in_instr      in   INSTR_W  instruction from instruction memory
//  flush         in   1        synchronous squash of all held entries (branch/jump taken)
//  out_valid     out  1        decode-side entry valid
//  out_ready     in   1        decode consumes the entry (low = hazard stall)
//  out_pc_plus4  out  ADDR_W   PC+4 of the head entry
//  out_opcode    out  6        instr[31:26]
//  out_rs        out  5        instr[25:21]
//  out_rt        out  5        instr[20:16]
//  out_rd        out  5        instr[15:11]
//  out_funct     out  6        instr[5:0]
//  out_imm       out  16       instr[15:0]
//  occupancy     out  2        number of held entries: 0, 1 or 2 (2 only when SKID=1)
// BEHAVIOUR
//  - Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready.
//  - Latency: an accepted word appears on the outputs in the next cycle. Zero bubbles
//    when out_ready stays high.
//  - Reset (rst_n low, asynchronous): all outputs 0, occupancy 0, out_valid 0.
//    in_ready is 1 one cycle after rst_n deasserts.
//  - SKID=1, states EMPTY/ONE/TWO (head register + skid register):
//     EMPTY: accept -> ONE (head is loaded).
//     ONE:   accept & consume -> ONE (head reloaded); accept & !consume -> TWO
//            (skid is loaded); consume & !accept -> EMPTY.
//     TWO:   in_ready = 0; consume -> ONE (head <- skid); otherwise hold.
//     in_ready = (state != TWO), driven directly from a flop.
//  - SKID=0: head only. in_ready = !out_valid | out_ready (combinational);
//    occupancy never exceeds 1.
//  - Stall: while out_valid & !out_ready, every output is held bit-stable.
//  - Flush: has priority over every transfer in the same cycle. Next cycle:
//    state EMPTY, out_valid 0, and all payload/field outputs 0 (a zero word decodes as
//    a NOP). A word accepted in the flush cycle is discarded. A consume in the flush
//    cycle still counts on the decode side.
//  - Invalid head: payload outputs keep their last value, except after reset or flush,
//    when they are 0. Consumers qualify every output with out_valid.
//  - Ordering: strict FIFO order; entries are never dropped or duplicated except by
//    flush.
//  - Invariant: occupancy == 0 exactly when out_valid == 0.
// STRUCTURE
//  - Shared package mips_pipe_pkg: field-slice localparams (OPC_HI=31, RS_HI=25,
//    RT_HI=20, RD_HI=15, FUNCT_HI=5, IMM_HI=15), the NOP word constant, and the
//    occupancy encoding.
//  - One natural sub-module: instr_field_split (combinational slicer, used on the head
//    register output). The handshake/state logic stays in this module.
// TESTING
//  1 Reset: drive rst_n low mid-stream while TWO -> all outputs 0, occupancy 0
//    asynchronously; in_ready 1 one cycle after release.
//  2 Streaming: out_ready=1, feed instr 0x012A4020 at PC+4 0x04, 0x08, 0x0C on
//    consecutive cycles -> each appears one cycle later, opcode 0, rs 9, rt 10, rd 8,
//    funct 0x20, no bubbles.
//  3 Skid: SKID=1, out_ready=0 after the first word -> second word held, in_ready
//    drops, occupancy 2. Raise out_ready -> words emerge in order, occupancy 2->1->0.
//  4 Flush priority: occupancy 2, assert flush with in_valid=1 -> next cycle
//    out_valid 0, all fields 0, occupancy 0; the flush-cycle word never emerges.
//  5 SKID=0: out_ready=0 with occupancy 1 -> in_ready 0 in the same cycle. Toggle
//    out_ready -> one word per consume, no loss.
//  6 Random in_valid/out_ready/flush for 10k cycles against a queue model -> output
//    order matches, no overflow, invariant holds.

Source files
------------

// File: rtl/if_id_skid_stage_pkg.sv
// ------------------------------------------------------------------
// mips_pipe_pkg : shared IF/ID field slices, NOP word, occupancy codes
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mips_pipe_pkg;

  localparam int OPC_HI   = 31;
  localparam int OPC_W    = 6;
  localparam int RS_HI    = 25;
  localparam int RT_HI    = 20;
  localparam int RD_HI    = 15;
  localparam int REG_W    = 5;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_HI   = 15;
  localparam int IMM_W    = 16;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

`default_nettype wire

// File: rtl/if_id_skid_stage_if.sv
// ------------------------------------------------------------------
// if_id_skid_stage_if : fetch-side and decode-side handshake bundle
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface if_id_skid_stage_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);

  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  in_pc_plus4;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc_plus4;
  logic [5:0]         out_opcode;
  logic [4:0]         out_rs;
  logic [4:0]         out_rt;
  logic [4:0]         out_rd;
  logic [5:0]         out_funct;
  logic [15:0]        out_imm;
  logic [1:0]         occupancy;

  modport slave (
    input  in_valid, in_pc_plus4, in_instr, out_ready,
    output in_ready, out_valid, out_pc_plus4, out_opcode, out_rs, out_rt,
           out_rd, out_funct, out_imm, occupancy
  );

  modport master (
    output in_valid, in_pc_plus4, in_instr, out_ready,
    input  in_ready, out_valid, out_pc_plus4, out_opcode, out_rs, out_rt,
           out_rd, out_funct, out_imm, occupancy
  );

endinterface

`default_nettype wire

// File: rtl/if_id_skid_stage_instr_field_split.sv
// ------------------------------------------------------------------
// instr_field_split : combinational MIPS field slicer on a 32-bit word
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module instr_field_split
  import mips_pipe_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm_o
);

  assign opcode_o = instr_i[OPC_HI   -: OPC_W];
  assign rs_o     = instr_i[RS_HI    -: REG_W];
  assign rt_o     = instr_i[RT_HI    -: REG_W];
  assign rd_o     = instr_i[RD_HI    -: REG_W];
  assign funct_o  = instr_i[FUNCT_HI -: FUNCT_W];
  assign imm_o    = instr_i[IMM_HI   -: IMM_W];

endmodule

`default_nettype wire

// File: rtl/if_id_skid_stage.sv
// ------------------------------------------------------------------
// if_id_skid_stage : IF/ID valid/ready stage with optional skid entry
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module if_id_skid_stage
  import mips_pipe_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int SKID    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  if_id_skid_stage_if.slave  bus
);

  occ_e               state_q;
  occ_e               state_d;
  logic [ADDR_W-1:0]  head_pc_q;
  logic [INSTR_W-1:0] head_instr_q;
  logic [ADDR_W-1:0]  skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               in_ready;
  logic               accept;
  logic               consume;
  logic               load_head_in;
  logic               load_head_skid;

  assign accept         = bus.in_valid & in_ready;
  assign consume        = (state_q != OCC_EMPTY) & bus.out_ready;
  assign load_head_in   = accept & ((state_q == OCC_EMPTY) | ((state_q == OCC_ONE) & consume));
  assign load_head_skid = (state_q == OCC_TWO) & consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ONE -> TWO only happens with SKID=1: without skid, accept implies consume.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (accept) state_d = OCC_ONE;
        OCC_ONE: begin
          if (accept && !consume)      state_d = OCC_TWO;
          else if (!accept && consume) state_d = OCC_EMPTY;
        end
        OCC_TWO:   if (consume) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  always_comb begin
    bus.out_valid = (state_q != OCC_EMPTY);
    bus.occupancy = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_pc_q    <= '0;
      head_instr_q <= INSTR_W'(NOP_WORD);
    end else if (flush) begin
      head_pc_q    <= '0;
      head_instr_q <= INSTR_W'(NOP_WORD);
    end else if (load_head_in) begin
      head_pc_q    <= bus.in_pc_plus4;
      head_instr_q <= bus.in_instr;
    end else if (load_head_skid) begin
      head_pc_q    <= skid_pc;
      head_instr_q <= skid_instr;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [ADDR_W-1:0]  skid_pc_q;
      logic [INSTR_W-1:0] skid_instr_q;
      logic               in_ready_q;
      logic               load_skid;

      assign load_skid = accept & (state_q == OCC_ONE) & ~consume;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_pc_q    <= '0;
          skid_instr_q <= INSTR_W'(NOP_WORD);
        end else if (flush) begin
          skid_pc_q    <= '0;
          skid_instr_q <= INSTR_W'(NOP_WORD);
        end else if (load_skid) begin
          skid_pc_q    <= bus.in_pc_plus4;
          skid_instr_q <= bus.in_instr;
        end
      end

      // Ready is a pure flop so decode stalls never reach fetch combinationally.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_ready_q <= 1'b0;
        end else begin
          in_ready_q <= (state_d != OCC_TWO);
        end
      end

      assign skid_pc    = skid_pc_q;
      assign skid_instr = skid_instr_q;
      assign in_ready   = in_ready_q;
    end else begin : g_no_skid
      logic ready_en_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ready_en_q <= 1'b0;
        end else begin
          ready_en_q <= 1'b1;
        end
      end

      assign skid_pc    = '0;
      assign skid_instr = '0;
      assign in_ready   = ready_en_q & ((state_q == OCC_EMPTY) | bus.out_ready);
    end
  endgenerate

  assign bus.in_ready     = in_ready;
  assign bus.out_pc_plus4 = head_pc_q;

  instr_field_split u_split (
    .instr_i  (head_instr_q[31:0]),
    .opcode_o (bus.out_opcode),
    .rs_o     (bus.out_rs),
    .rt_o     (bus.out_rt),
    .rd_o     (bus.out_rd),
    .funct_o  (bus.out_funct),
    .imm_o    (bus.out_imm)
  );

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_stage.sv
// ------------------------------------------------------------------
// tb_if_id_skid_stage : SKID=1 and SKID=0 instances against a FIFO model
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_if_id_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;

  always #5 clk = ~clk;

  if_id_skid_stage_if #(.ADDR_W(32), .INSTR_W(32)) b1 ();
  if_id_skid_stage_if #(.ADDR_W(32), .INSTR_W(32)) b0 ();

  assign b1.in_valid    = in_valid;
  assign b1.in_pc_plus4 = in_pc;
  assign b1.in_instr    = in_instr;
  assign b1.out_ready   = out_ready;
  assign b0.in_valid    = in_valid;
  assign b0.in_pc_plus4 = in_pc;
  assign b0.in_instr    = in_instr;
  assign b0.out_ready   = out_ready;

  if_id_skid_stage #(.ADDR_W(32), .INSTR_W(32), .SKID(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b1)
  );

  if_id_skid_stage #(.ADDR_W(32), .INSTR_W(32), .SKID(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b0)
  );

  // Reference: per-instance FIFO of {pc, instr}, capacity 2 (skid) or 1.
  logic [63:0] mq    [2][2];
  int          mcnt  [2];
  logic [63:0] mdisp [2];
  bit          mrdy_en [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit exp_rdy(input int d);
    if (!mrdy_en[d]) return 1'b0;
    if (d == 1) return (mcnt[1] < 2);
    return (mcnt[0] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d]    = 0;
      mdisp[d]   = '0;
      mrdy_en[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    bit acc;
    bit con;
    acc = in_valid && exp_rdy(d);
    con = (mcnt[d] > 0) && out_ready;
    mrdy_en[d] = 1'b1;
    if (flush) begin
      mcnt[d]  = 0;
      mdisp[d] = '0;
    end else begin
      if (con) begin
        mq[d][0] = mq[d][1];
        mcnt[d]--;
      end
      if (acc) begin
        mq[d][mcnt[d]] = {in_pc, in_instr};
        mcnt[d]++;
      end
      if (mcnt[d] > 0) mdisp[d] = mq[d][0];
    end
  endtask

  task automatic compare(input int d);
    logic        rdy;
    logic        vld;
    logic [1:0]  occ;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [4:0]  rd;
    logic [5:0]  fn;
    logic [31:0] epc;
    logic [31:0] eins;
    if (d == 1) begin
      rdy = b1.in_ready;  vld = b1.out_valid;  occ = b1.occupancy;
      pc  = b1.out_pc_plus4;
      ins = {b1.out_opcode, b1.out_rs, b1.out_rt, b1.out_imm};
      rd  = b1.out_rd;    fn  = b1.out_funct;
    end else begin
      rdy = b0.in_ready;  vld = b0.out_valid;  occ = b0.occupancy;
      pc  = b0.out_pc_plus4;
      ins = {b0.out_opcode, b0.out_rs, b0.out_rt, b0.out_imm};
      rd  = b0.out_rd;    fn  = b0.out_funct;
    end
    epc  = mdisp[d][63:32];
    eins = mdisp[d][31:0];
    check_eq($sformatf("d%0d_in_ready", d), 64'(rdy), 64'(exp_rdy(d)));
    check_eq($sformatf("d%0d_out_valid", d), 64'(vld), 64'(mcnt[d] > 0));
    check_eq($sformatf("d%0d_occupancy", d), 64'(occ), 64'(mcnt[d]));
    check_eq($sformatf("d%0d_occ_cap", d), 64'(occ <= ((d == 1) ? 2'd2 : 2'd1)), 64'd1);
    check_eq($sformatf("d%0d_occ_inv", d), 64'(occ == 2'd0), 64'(vld == 1'b0));
    check_eq($sformatf("d%0d_pc", d), 64'(pc), 64'(epc));
    check_eq($sformatf("d%0d_instr", d), 64'(ins), 64'(eins));
    check_eq($sformatf("d%0d_rd", d), 64'(rd), 64'(eins[15:11]));
    check_eq($sformatf("d%0d_funct", d), 64'(fn), 64'(eins[5:0]));
  endtask

  task automatic tick();
    @(negedge clk);
    compare(1);
    compare(0);
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(1);
      model_step(0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    in_valid = v;
    in_pc    = pc;
    in_instr = ins;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    model_reset();
    tick();
    tick();
    check_eq("rst_out_valid", 64'(b1.out_valid), 64'd0);
    check_eq("rst_occupancy", 64'(b1.occupancy), 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_rdy_after_release", 64'(b1.in_ready), 64'd1);

    // Streaming with no back-pressure.
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 32'(4 * k), 32'h012A_4020);
      tick();
      check_eq("t2_valid", 64'(b1.out_valid), 64'd1);
      check_eq("t2_pc", 64'(b1.out_pc_plus4), 64'(4 * k));
      check_eq("t2_opcode", 64'(b1.out_opcode), 64'd0);
      check_eq("t2_rs", 64'(b1.out_rs), 64'd9);
      check_eq("t2_rt", 64'(b1.out_rt), 64'd10);
      check_eq("t2_rd", 64'(b1.out_rd), 64'd8);
      check_eq("t2_funct", 64'(b1.out_funct), 64'h20);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // Skid fill and drain.
    drive(1'b1, 32'h10, 32'h2108_0001);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h14, 32'h2108_0002);
    tick();
    check_eq("t3_occ2", 64'(b1.occupancy), 64'd2);
    check_eq("t3_rdy_low", 64'(b1.in_ready), 64'd0);
    drive(1'b1, 32'h18, 32'h2108_0003);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    check_eq("t3_second_word", 64'(b1.out_pc_plus4), 64'h14);
    tick();
    tick();

    // Asynchronous reset while full.
    out_ready = 1'b0;
    drive(1'b1, 32'h20, 32'h8C22_0004);
    tick();
    drive(1'b1, 32'h24, 32'h8C22_0008);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare(1);
    compare(0);
    check_eq("t1_async_occ", 64'(b1.occupancy), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t1_rdy_after_release", 64'(b1.in_ready), 64'd1);

    // Flush beats a same-cycle accept.
    drive(1'b1, 32'h40, 32'h0000_0020);
    tick();
    drive(1'b1, 32'h44, 32'h0000_0022);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'hF4, 32'hFFFF_FFFF);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check_eq("t4_valid", 64'(b1.out_valid), 64'd0);
    check_eq("t4_occ", 64'(b1.occupancy), 64'd0);
    check_eq("t4_pc", 64'(b1.out_pc_plus4), 64'd0);
    check_eq("t4_imm", 64'(b1.out_imm), 64'd0);
    out_ready = 1'b1;
    tick();
    tick();

    // No-skid instance: combinational ready drop, then toggled out_ready.
    drive(1'b1, 32'h30, 32'h0128_5825);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h34, 32'h0128_5826);
    #1;
    check_eq("t5_rdy0_same_cycle", 64'(b0.in_ready), 64'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      out_ready = i[0];
      drive(1'b1, 32'(32'h38 + 4 * i), 32'(32'h0128_5800 + i));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    tick();
    tick();

    // Random traffic.
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
